// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Purpose  : Receive-side quadrature (A/B) decoder. Synchronizes and
//            debounces the asynchronous encoder phases, decodes Gray-code
//            transitions into step/direction events and drives a WIDTH-bit
//            wrapping up/down position counter. Illegal double transitions
//            raise a sticky error flag instead of counting.
// Ports    : clk      - system clock, all logic on posedge
//            rst      - synchronous active-high reset
//            a, b     - encoder phases A/B (asynchronous)
//            z        - index pulse (asynchronous), only with QUAD_INDEX_EN
//            load     - one-cycle preset strobe, cont <= load_val
//            load_val - preset value
//            clr_err  - clears the sticky err flag
//            cont     - position count
//            step     - one-cycle pulse per accepted legal transition
//            ud       - direction of last legal step (1 = up, 0 = down)
//            err      - sticky illegal-transition flag
// Options  : define QUAD_INDEX_EN to add the z index input; a filtered
//            rising edge of z zeroes cont (below load, above counting).
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
`ifdef QUAD_INDEX_EN
    input  logic             z,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] cont,
    output logic             step,
    output logic             ud,
    output logic             err
);

    // Channel vector layout: bit1 = A, bit0 = B, bit2 = Z (when present).
`ifdef QUAD_INDEX_EN
    localparam int c_CH_W = 3;
`else
    localparam int c_CH_W = 2;
`endif

    localparam int                 c_CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FILTER_LEN);

    localparam logic [0:0] c_ST_UNPRIMED = 1'b0;
    localparam logic [0:0] c_ST_TRACK    = 1'b1;

    // Map a Gray-coded {a,b} pair to its position in the up sequence
    // 00 -> 01 -> 11 -> 10, so a modulo-4 difference classifies a move.
    function automatic logic [1:0] f_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    logic [c_CH_W-1:0]  w_pins;
    logic [c_CH_W-1:0]  r_sync [SYNC_STAGES];
    logic [c_CH_W-1:0]  w_cand;
    logic [c_CH_W-1:0]  r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CH_W-1:0]  r_filt;
    logic               w_accept;
    logic [1:0]         w_delta;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CH_W-1:0]  w_filt_nxt;
    logic [WIDTH-1:0]   r_cont;
    logic [WIDTH-1:0]   w_cont_nxt;
    logic               r_step;
    logic               w_step_nxt;
    logic               r_ud;
    logic               w_ud_nxt;
    logic               r_err;
    logic               w_err_nxt;

`ifdef QUAD_INDEX_EN
    assign w_pins = {z, a, b};
`else
    assign w_pins = {a, b};
`endif

    // Input synchronizer chains, one column per channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_cand = r_sync[SYNC_STAGES-1];

    // Stability filter: r_cnt holds how many consecutive edges have seen
    // the value now in r_cand. A value is accepted on the edge after it has
    // been seen FILTER_LEN times, which makes the pin-to-output latency
    // exactly SYNC_STAGES + FILTER_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else begin
            r_cand <= w_cand;
            if (w_cand != r_cand) begin
                r_cnt <= c_CNT_ONE;
            end else if (r_cnt != c_CNT_FULL) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign w_accept = (r_cnt == c_CNT_FULL) && (r_cand != r_filt);
    assign w_delta  = f_pos(r_cand[1:0]) - f_pos(r_filt[1:0]);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_UNPRIMED;
            r_filt  <= '0;
            r_cont  <= '0;
            r_step  <= 1'b0;
            r_ud    <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_filt  <= w_filt_nxt;
            r_cont  <= w_cont_nxt;
            r_step  <= w_step_nxt;
            r_ud    <= w_ud_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_filt_nxt  = r_filt;
        w_cont_nxt  = r_cont;
        w_step_nxt  = 1'b0;
        w_ud_nxt    = r_ud;
        w_err_nxt   = clr_err ? 1'b0 : r_err;

        case (r_state)
            c_ST_UNPRIMED: begin
                // First accepted value only establishes the reference phase.
                if (w_accept) begin
                    w_filt_nxt  = r_cand;
                    w_state_nxt = c_ST_TRACK;
                end
            end
            c_ST_TRACK: begin
                if (w_accept) begin
                    w_filt_nxt = r_cand;
                    case (w_delta)
                        2'd1: begin
                            w_step_nxt = 1'b1;
                            w_ud_nxt   = 1'b1;
                            w_cont_nxt = r_cont + 1'b1;
                        end
                        2'd3: begin
                            w_step_nxt = 1'b1;
                            w_ud_nxt   = 1'b0;
                            w_cont_nxt = r_cont - 1'b1;
                        end
                        2'd2: begin
                            // Both phases moved at once: direction unknown.
                            w_err_nxt = 1'b1;
                        end
                        default: begin
                            // A/B unchanged (only the index channel moved).
                        end
                    endcase
`ifdef QUAD_INDEX_EN
                    if (r_cand[2] && !r_filt[2]) begin
                        w_cont_nxt = '0;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = c_ST_UNPRIMED;
            end
        endcase

        // Preset overrides any counting or index clear in the same cycle.
        if (load) begin
            w_cont_nxt = load_val;
        end
    end

    assign cont = r_cont;
    assign step = r_step;
    assign ud   = r_ud;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_quad_decoder
// Purpose  : Self-checking bench for quad_decoder. Directed pin sequences
//            push the expected {cont, ud, arrival cycle} of each step into a
//            scoreboard queue; a negedge monitor pops and compares on every
//            step pulse. Static state (err, cont, reset values) is checked
//            directly between moves. Define QUAD_INDEX_EN to cover z.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;
    localparam int c_LAT       = SYNC_STAGES + FILTER_LEN;

    typedef struct {
        logic [WIDTH-1:0] cont;
        logic             ud;
        int               at;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic             b;
`ifdef QUAD_INDEX_EN
    logic             z;
`endif
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_err;
    logic [WIDTH-1:0] cont;
    logic             step;
    logic             ud;
    logic             err;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    quad_decoder #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
`ifdef QUAD_INDEX_EN
        .z        (z),
`endif
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .cont     (cont),
        .step     (step),
        .ud       (ud),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Monitor: every step pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && step !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected step", 32'(step), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("step cont", 32'(cont), 32'(mon_e.cont));
                chk("step ud",   32'(ud),   32'(mon_e.ud));
                chk("step time", 32'(cyc),  32'(mon_e.at));
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Legal move: expected step lands c_LAT cycles after the sampling edge.
    task automatic move(input logic na, input logic nb,
                        input logic [WIDTH-1:0] ec, input logic eu);
        @(posedge clk); #1;
        a = na; b = nb;
        sb.push_back('{ec, eu, cyc + c_LAT + 1});
        settle(10);
    endtask

    // Pin change that must not produce a step.
    task automatic quiet(input logic na, input logic nb);
        @(posedge clk); #1;
        a = na; b = nb;
        settle(10);
    endtask

    task automatic load_pulse(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        load = 1'b1; load_val = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    // Legal move with load asserted on the very edge the step completes.
    task automatic move_load(input logic na, input logic nb,
                             input logic [WIDTH-1:0] lv, input logic eu);
        @(posedge clk); #1;
        a = na; b = nb;
        sb.push_back('{lv, eu, cyc + c_LAT + 1});
        settle(c_LAT);
        load = 1'b1; load_val = lv;
        @(posedge clk); #1;
        load = 1'b0;
        settle(8);
    endtask

    // Illegal move with clr_err asserted on the acceptance edge.
    task automatic illegal_clr(input logic na, input logic nb);
        @(posedge clk); #1;
        a = na; b = nb;
        settle(c_LAT);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("err held vs clr", 32'(err), 32'd1);
        settle(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] c;
        rst = 1'b1; a = 1'b1; b = 1'b1; load = 1'b0; load_val = '0;
        clr_err = 1'b0;
`ifdef QUAD_INDEX_EN
        z = 1'b0;
`endif
        settle(3);
        chk("reset cont", 32'(cont), 32'h00);
        chk("reset step", 32'(step), 32'd0);
        chk("reset ud",   32'(ud),   32'd1);
        chk("reset err",  32'(err),  32'd0);
        rst = 1'b0;

        // Pins held at 11 through reset: priming must not count.
        settle(12);
        chk("primed cont", 32'(cont), 32'h00);
        chk("primed err",  32'(err),  32'd0);

        // Walk down to 00, then preset to zero.
        move(1'b0, 1'b1, 8'hFF, 1'b0);
        move(1'b0, 1'b0, 8'hFE, 1'b0);
        load_pulse(8'h00);
        settle(1);
        chk("load zero", 32'(cont), 32'h00);

        // Four forward cycles: 16 up steps.
        c = 8'h00;
        for (int i = 0; i < 4; i++) begin
            c = c + 1'b1; move(1'b0, 1'b1, c, 1'b1);
            c = c + 1'b1; move(1'b1, 1'b1, c, 1'b1);
            c = c + 1'b1; move(1'b1, 1'b0, c, 1'b1);
            c = c + 1'b1; move(1'b0, 1'b0, c, 1'b1);
        end
        chk("forward cont", 32'(cont), 32'h10);
        chk("forward ud",   32'(ud),   32'd1);

        // Reverse from zero wraps down, forward from FF wraps up.
        load_pulse(8'h00);
        move(1'b1, 1'b0, 8'hFF, 1'b0);
        move(1'b0, 1'b0, 8'h00, 1'b1);

        // Two-cycle glitch on a must be filtered out.
        @(posedge clk); #1; a = 1'b1;
        @(posedge clk); @(posedge clk); #1; a = 1'b0;
        settle(12);
        chk("glitch cont", 32'(cont), 32'h00);

        // Illegal 00 -> 11: sticky err, nothing else changes.
        quiet(1'b1, 1'b1);
        chk("illegal err",  32'(err),  32'd1);
        chk("illegal cont", 32'(cont), 32'h00);
        chk("illegal ud",   32'(ud),   32'd1);
        clr_pulse();
        chk("clr err", 32'(err), 32'd0);

        // Counting resumes from the new reference phase.
        move(1'b1, 1'b0, 8'h01, 1'b1);

        // Illegal 10 -> 01, then 01 -> 10 coincident with clr_err.
        quiet(1'b0, 1'b1);
        chk("illegal2 err",  32'(err),  32'd1);
        chk("illegal2 cont", 32'(cont), 32'h01);
        illegal_clr(1'b1, 1'b0);
        clr_pulse();
        chk("clr2 err",  32'(err),  32'd0);
        chk("clr2 cont", 32'(cont), 32'h01);

        // Load on the step-completion edge: load value wins, step still fires.
        move_load(1'b0, 1'b0, 8'h7F, 1'b1);
        chk("load vs step cont", 32'(cont), 32'h7F);
        chk("load vs step ud",   32'(ud),   32'd1);

`ifdef QUAD_INDEX_EN
        @(posedge clk); #1; z = 1'b1;
        settle(12);
        chk("index clear", 32'(cont), 32'h00);
        @(posedge clk); #1; z = 1'b0;
        settle(12);
        chk("index fall", 32'(cont), 32'h00);
        load_pulse(8'h7F);
`endif

        move(1'b0, 1'b1, 8'h80, 1'b1);

        // Reset mid-filter: the pending 01 -> 11 change is discarded and the
        // held 11 only re-primes the decoder.
        @(posedge clk); #1;
        a = 1'b1; b = 1'b1;
        settle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst cont", 32'(cont), 32'h00);
        chk("midrst ud",   32'(ud),   32'd1);
        settle(12);
        chk("reprime cont", 32'(cont), 32'h00);
        move(1'b1, 1'b0, 8'h01, 1'b1);

        settle(10);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
